// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB fetch predictor with decode-stage resolution and training.
// Define BP_STATS_EN to add saturating branch_cnt/miss_cnt outputs.
module branch_predictor #(
    parameter int INDEX_WIDTH = 6,
    parameter int TAG_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_f,
    output logic        predict_taken_f,
    output logic [31:0] predict_target_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        is_branch_d,
    input  logic        taken_d,
    input  logic [31:0] branch_target_d,
    output logic        predict_miss,
    output logic [31:0] correct_pc_d
`ifdef BP_STATS_EN
    ,
    output logic [31:0] branch_cnt,
    output logic [31:0] miss_cnt
`endif
);
    localparam int ENTRIES = 1 << INDEX_WIDTH;
    localparam int TL = INDEX_WIDTH + 2;
    localparam int TH = INDEX_WIDTH + TAG_WIDTH + 1;

    logic                   valid_t  [ENTRIES];
    logic [TAG_WIDTH-1:0]   tag_t    [ENTRIES];
    logic [31:0]            target_t [ENTRIES];
    logic [1:0]             ctr_t    [ENTRIES];

    logic [INDEX_WIDTH-1:0] idx_f, idx_d;
    logic [TAG_WIDTH-1:0]   tag_f, tag_d;
    logic                   hit_f;
    logic                   valid_d, pred_taken_d, hit_d;
    logic [31:0]            pc_d, pred_target_d;
    logic                   raw_miss, train;
    logic [1:0]             ctr_cur, ctr_next;

    assign idx_f = pc_f[INDEX_WIDTH+1:2];
    assign tag_f = pc_f[TH:TL];
    assign idx_d = pc_d[INDEX_WIDTH+1:2];
    assign tag_d = pc_d[TH:TL];

    assign hit_f            = valid_t[idx_f] && tag_t[idx_f] == tag_f;
    assign predict_taken_f  = hit_f && ctr_t[idx_f][1];
    assign predict_target_f = hit_f ? target_t[idx_f] : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_d       <= 1'b0;
            pc_d          <= 32'd0;
            pred_taken_d  <= 1'b0;
            pred_target_d <= 32'd0;
            hit_d         <= 1'b0;
        end else if (!stall_d) begin
            valid_d       <= !flush_d;
            pc_d          <= pc_f;
            pred_taken_d  <= predict_taken_f;
            pred_target_d <= predict_target_f;
            hit_d         <= hit_f;
        end
    end

    // Non-branches only miss when an aliased entry steered fetch away.
    assign raw_miss = valid_d && (is_branch_d
                      ? (pred_taken_d != taken_d || (taken_d && pred_target_d != branch_target_d))
                      : pred_taken_d);
    assign predict_miss = raw_miss && !stall_d;
    assign correct_pc_d = !valid_d ? 32'd0
                        : (is_branch_d && taken_d) ? branch_target_d : pc_d + 32'd4;
    assign train        = valid_d && !stall_d;

    assign ctr_cur  = ctr_t[idx_d];
    assign ctr_next = taken_d ? (ctr_cur == 2'b11 ? 2'b11 : ctr_cur + 2'd1)
                              : (ctr_cur == 2'b00 ? 2'b00 : ctr_cur - 2'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_t[i]  <= 1'b0;
                tag_t[i]    <= '0;
                target_t[i] <= 32'd0;
                ctr_t[i]    <= 2'b01;
            end
        end else if (train) begin
            if (is_branch_d && hit_d) begin
                ctr_t[idx_d] <= ctr_next;
                if (taken_d)
                    target_t[idx_d] <= branch_target_d;
            end else if (is_branch_d && taken_d) begin
                valid_t[idx_d]  <= 1'b1;
                tag_t[idx_d]    <= tag_d;
                target_t[idx_d] <= branch_target_d;
                ctr_t[idx_d]    <= 2'b10;
            end else if (!is_branch_d && pred_taken_d) begin
                valid_t[idx_d]  <= 1'b0;
            end
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt <= 32'd0;
            miss_cnt   <= 32'd0;
        end else begin
            if (train && is_branch_d && branch_cnt != 32'hFFFF_FFFF)
                branch_cnt <= branch_cnt + 32'd1;
            if (predict_miss && miss_cnt != 32'hFFFF_FFFF)
                miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed test-plan scenarios plus randomized traffic checked against a behavioural BTB model.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_f = 32'd0;
    logic        predict_taken_f;
    logic [31:0] predict_target_f;
    logic        stall_d = 1'b0, flush_d = 1'b0, is_branch_d = 1'b0, taken_d = 1'b0;
    logic [31:0] branch_target_d = 32'd0;
    logic        predict_miss;
    logic [31:0] correct_pc_d;
`ifdef BP_STATS_EN
    logic [31:0] branch_cnt, miss_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk(clk), .rst_n(rst_n), .pc_f(pc_f),
        .predict_taken_f(predict_taken_f), .predict_target_f(predict_target_f),
        .stall_d(stall_d), .flush_d(flush_d), .is_branch_d(is_branch_d), .taken_d(taken_d),
        .branch_target_d(branch_target_d), .predict_miss(predict_miss), .correct_pc_d(correct_pc_d)
`ifdef BP_STATS_EN
        , .branch_cnt(branch_cnt), .miss_cnt(miss_cnt)
`endif
    );

    // Behavioural model: plain arrays, integer counters.
    bit          m_valid [64];
    int          m_tag   [64];
    logic [31:0] m_tgt   [64];
    int          m_ctr   [64];
    bit          md_valid, md_pt, md_hit;
    logic [31:0] md_pc, md_tgt;
    longint      m_br, m_miss;

    bit          f_hit, f_pt, e_miss;
    logic [31:0] f_tgt, e_cpc;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic int tag_of(input logic [31:0] pc);
        return int'((pc >> 8) % 256);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
        md_valid = 0; md_pt = 0; md_hit = 0; md_pc = 0; md_tgt = 0;
        m_br = 0; m_miss = 0;
    endtask

    task automatic eval();
        int i;
        bit wrong;
        i = idx_of(pc_f);
        f_hit = m_valid[i] && m_tag[i] == tag_of(pc_f);
        f_pt  = f_hit && m_ctr[i] >= 2;
        f_tgt = f_hit ? m_tgt[i] : 32'd0;
        if (is_branch_d)
            wrong = (md_pt != taken_d) || (taken_d && md_tgt != branch_target_d);
        else
            wrong = md_pt;
        e_miss = md_valid && wrong && !stall_d;
        if (!md_valid) e_cpc = 0;
        else if (is_branch_d && taken_d) e_cpc = branch_target_d;
        else e_cpc = md_pc + 32'd4;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic compare();
        eval();
        chk("predict_taken_f", {31'd0, predict_taken_f}, {31'd0, f_pt});
        chk("predict_target_f", predict_target_f, f_tgt);
        chk("predict_miss", {31'd0, predict_miss}, {31'd0, e_miss});
        chk("correct_pc_d", correct_pc_d, e_cpc);
`ifdef BP_STATS_EN
        chk("branch_cnt", branch_cnt, m_br > 64'hFFFFFFFF ? 32'hFFFFFFFF : m_br[31:0]);
        chk("miss_cnt", miss_cnt, m_miss > 64'hFFFFFFFF ? 32'hFFFFFFFF : m_miss[31:0]);
`endif
    endtask

    task automatic drive(input logic [31:0] pc, input bit st, input bit fl,
                         input bit br, input bit tk, input logic [31:0] bt);
        pc_f = pc; stall_d = st; flush_d = fl; is_branch_d = br; taken_d = tk; branch_target_d = bt;
        @(negedge clk);
        compare();
    endtask

    // Advance the model across the coming rising edge, then let the DUT take it.
    task automatic tick();
        int i;
        eval();
        if (e_miss) m_miss++;
        if (md_valid && !stall_d) begin
            i = idx_of(md_pc);
            if (is_branch_d) m_br++;
            if (is_branch_d && md_hit) begin
                m_ctr[i] = taken_d ? (m_ctr[i] < 3 ? m_ctr[i] + 1 : 3) : (m_ctr[i] > 0 ? m_ctr[i] - 1 : 0);
                if (taken_d) m_tgt[i] = branch_target_d;
            end else if (is_branch_d && taken_d) begin
                m_valid[i] = 1; m_tag[i] = tag_of(md_pc); m_tgt[i] = branch_target_d; m_ctr[i] = 2;
            end else if (!is_branch_d && md_pt) begin
                m_valid[i] = 0;
            end
        end
        if (!stall_d) begin
            md_valid = !flush_d;
            md_pc = pc_f; md_pt = f_pt; md_tgt = f_tgt; md_hit = f_hit;
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] B = 32'h0040_0010;
    localparam logic [31:0] N = 32'h0040_0014;
    localparam logic [31:0] T = 32'h0040_0040;

    logic [31:0] pc_pool [8] = '{32'h0040_0010, 32'h0040_0014, 32'h0040_0110, 32'h0040_0018,
                                 32'h1234_5678, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0040_0020};
    logic [31:0] tg_pool [4] = '{32'h0040_0040, 32'h0040_0080, 32'h0000_1000, 32'h0040_0010};

    initial begin
        model_reset();
        #3;
        chk("reset predict_taken_f", {31'd0, predict_taken_f}, 32'd0);
        chk("reset predict_target_f", predict_target_f, 32'd0);
        chk("reset predict_miss", {31'd0, predict_miss}, 32'd0);
        chk("reset correct_pc_d", correct_pc_d, 32'd0);
        #4 rst_n = 1'b1;

        // Cold miss
        drive(B, 0, 0, 0, 0, 0);         chk("cold taken_f", {31'd0, predict_taken_f}, 32'd0); tick();
        drive(N, 0, 0, 1, 1, T);         chk("cold miss", {31'd0, predict_miss}, 32'd1);
                                         chk("cold cpc", correct_pc_d, T); tick();
        drive(B, 0, 0, 0, 0, 0);         chk("learned taken_f", {31'd0, predict_taken_f}, 32'd1);
                                         chk("learned target_f", predict_target_f, T); tick();
        // Hysteresis: T, T, NT, NT
        drive(N, 0, 0, 1, 1, T);         chk("hys1 miss", {31'd0, predict_miss}, 32'd0); tick();
        drive(B, 0, 0, 0, 0, 0);         tick();
        drive(N, 0, 0, 1, 1, T);         chk("hys2 miss", {31'd0, predict_miss}, 32'd0); tick();
        drive(B, 0, 0, 0, 0, 0);         tick();
        drive(N, 0, 0, 1, 0, 0);         chk("hys3 miss", {31'd0, predict_miss}, 32'd1);
                                         chk("hys3 cpc", correct_pc_d, N); tick();
        drive(B, 0, 0, 0, 0, 0);         chk("hys ctr2 taken_f", {31'd0, predict_taken_f}, 32'd1); tick();
        drive(N, 0, 0, 1, 0, 0);         chk("hys4 miss", {31'd0, predict_miss}, 32'd1); tick();
        drive(B, 0, 0, 0, 0, 0);         chk("hys ctr1 taken_f", {31'd0, predict_taken_f}, 32'd0); tick();
        // Stall suppression
        drive(B, 1, 0, 1, 1, T);         chk("stall1 miss", {31'd0, predict_miss}, 32'd0); tick();
        drive(B, 1, 0, 1, 1, T);         chk("stall2 miss", {31'd0, predict_miss}, 32'd0);
                                         chk("stall ctr held", {31'd0, predict_taken_f}, 32'd0); tick();
        drive(N, 0, 0, 1, 1, T);         chk("unstall miss", {31'd0, predict_miss}, 32'd1);
                                         chk("unstall cpc", correct_pc_d, T); tick();
        drive(B, 0, 0, 0, 0, 0);         chk("unstall ctr2", {31'd0, predict_taken_f}, 32'd1); tick();
        drive(N, 0, 0, 1, 1, T);         tick();
        // Flush
        drive(B, 0, 1, 0, 0, 0);         chk("flush taken_f", {31'd0, predict_taken_f}, 32'd1); tick();
        drive(N, 0, 0, 1, 0, 0);         chk("flushed miss", {31'd0, predict_miss}, 32'd0);
                                         chk("flushed cpc", correct_pc_d, 32'd0); tick();
        drive(B, 0, 0, 0, 0, 0);         chk("flush no write", {31'd0, predict_taken_f}, 32'd1); tick();
        // Alias
        drive(N, 0, 0, 0, 0, 0);         chk("alias miss", {31'd0, predict_miss}, 32'd1);
                                         chk("alias cpc", correct_pc_d, N); tick();
        drive(B, 0, 0, 0, 0, 0);         chk("alias invalidated", {31'd0, predict_taken_f}, 32'd0);
                                         chk("alias target", predict_target_f, 32'd0); tick();
        // Wraparound and async reset
        drive(32'hFFFF_FFFC, 0, 0, 1, 1, T); tick();
        drive(B, 0, 0, 0, 0, 0);         chk("wrap cpc", correct_pc_d, 32'd0);
                                         chk("retrained taken_f", {31'd0, predict_taken_f}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async taken_f", {31'd0, predict_taken_f}, 32'd0);
        chk("async target_f", predict_target_f, 32'd0);
        chk("async cpc", correct_pc_d, 32'd0);
`ifdef BP_STATS_EN
        chk("async branch_cnt", branch_cnt, 32'd0);
        chk("async miss_cnt", miss_cnt, 32'd0);
`endif
        model_reset();
        #1 rst_n = 1'b1;
        tick();

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            drive(pc_pool[$urandom_range(0, 7)],
                  $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1,
                  tg_pool[$urandom_range(0, 3)]);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Fetch-stage dynamic branch predictor and decode-stage resolver; producer of the predict_miss signal consumed by the pipeline hazard logic.
- Fetch: direct-mapped branch target buffer (BTB) with 2-bit saturating counters supplies a predicted next PC.
- Decode: the prediction is carried alongside the instruction and compared with the resolved branch outcome, which is available in decode because operands are forwarded there.
- On mismatch: asserts predict_miss and supplies the corrected PC; the table is trained whenever decode advances.

Parameters:
INDEX_WIDTH, 6, log2 of BTB entries (64).
TAG_WIDTH, 8, PC tag bits stored per entry.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
pc_f  input  32  fetch PC
predict_taken_f  output  1  fetch should redirect to predict_target_f
predict_target_f  output  32  predicted target
stall_d  input  1  decode stalled; hold the decode prediction register, suppress miss/training
flush_d  input  1  decode bubble on next edge
is_branch_d  input  1  decode instruction is a conditional branch
taken_d  input  1  resolved branch direction
branch_target_d  input  32  resolved branch target
predict_miss  output  1  fetch path is wrong; redirect and flush
correct_pc_d  output  32  redirect PC when predict_miss=1

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Address fields:
  - idx = pc[INDEX_WIDTH+1:2]
  - tag = pc[INDEX_WIDTH+TAG_WIDTH+1:INDEX_WIDTH+2]
- BTB entry contents: valid, tag, target[31:0], ctr[1:0].
- Reset: every valid=0 and ctr=2'b01; decode register valid_d=0. Resulting outputs: predict_taken_f=0, predict_target_f=0, predict_miss=0, correct_pc_d=0.
- Fetch lookup (combinational, zero latency):
  - hit_f = valid[idx_f] && tag[idx_f]==tag_f
  - predict_taken_f = hit_f && ctr[idx_f][1]
  - predict_target_f = hit_f ? target[idx_f] : 0
- Decode register, captured at each rising edge:
  - stall_d=1: hold all fields (stall has priority over flush_d).
  - else flush_d=1: valid_d=0.
  - else: valid_d=1, pc_d=pc_f, pred_taken_d=predict_taken_f, pred_target_d=predict_target_f, hit_d=hit_f.
- Resolution (combinational):
  - raw_miss = valid_d && (is_branch_d ? (pred_taken_d!=taken_d || (taken_d && pred_target_d!=branch_target_d)) : pred_taken_d)
  - predict_miss = raw_miss && !stall_d. A stalled branch's operands are not final, so no miss is reported while stalled.
  - correct_pc_d = (is_branch_d && taken_d) ? branch_target_d : pc_d+4. Driven whenever valid_d; 0 when valid_d=0.
- Training, at the edge where valid_d && !stall_d, using the entry at idx_d:
  - is_branch_d && hit_d: ctr increments (taken) or decrements (not taken), saturating at 3/0. If taken, target <= branch_target_d.
  - is_branch_d && !hit_d && taken_d: allocate/replace the entry: valid=1, tag=tag_d, target=branch_target_d, ctr=2'b10.
  - is_branch_d && !hit_d && !taken_d: no write.
  - !is_branch_d && pred_taken_d (alias): valid <= 0 for that entry.
- Same-cycle lookup and update on the same index: the lookup sees the pre-update contents; there is no bypass.
- Reset asserted mid-operation clears the table immediately, with no edge required; any in-flight prediction is discarded.
- Arithmetic: pc_d+4 is 32-bit modulo; 0xFFFFFFFC+4 wraps to 0.

Optional Feature:
BP_STATS_EN
- Defined: adds outputs branch_cnt[31:0] and miss_cnt[31:0].
  - branch_cnt increments on each training edge with is_branch_d=1.
  - miss_cnt increments on each edge where predict_miss=1.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Cold miss: after reset, pc_f=0x00400010, then decode with is_branch_d=1, taken_d=1, target 0x00400040 -> predict_taken_f=0, predict_miss=1, correct_pc_d=0x00400040; next fetch of 0x00400010 gives predict_taken_f=1, predict_target_f=0x00400040.
- Counter hysteresis: same branch resolves taken, taken, not-taken, not-taken -> ctr steps 2,3,3,2,1; the third resolution misses with correct_pc_d=0x00400014, the fourth misses too (ctr=2 predicted taken), and the next prediction is not-taken.
- Stall suppression: branch mispredicted in decode with stall_d=1 for 2 cycles -> predict_miss=0 and ctr unchanged during the stall; predict_miss=1 on the first cycle with stall_d=0, and the counter updates exactly once.
- Flush: flush_d=1 with pc_f holding a predicted-taken branch -> next cycle valid_d=0, predict_miss=0, no table write.
- Alias: entry hit for pc 0x00400010, decode of non-branch at that PC with pred_taken_d=1 -> predict_miss=1, correct_pc_d=0x00400014, entry invalidated.
- Async reset mid-run: drop rst_n between edges after training -> predict_taken_f=0 immediately; with BP_STATS_EN defined, branch_cnt=miss_cnt=0.
